// File: rtl/led_scan_display_pkg.sv
// Shared types and constants for the LED scan display: segment/code types and the hex glyph table.
package led_pkg;

  typedef logic [7:0] seg_t;
  typedef logic [4:0] code_t;

  localparam seg_t  SEG_OFF    = 8'hFF;
  localparam code_t BLANK_CODE = 5'h1F;

  // Active-low {a,b,c,d,e,f,g,dp}, dp held off; index is the hex value.
  localparam seg_t GLYPHS [16] = '{
    8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
    8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
    8'b00000001, 8'b00001001, 8'b00010001, 8'b11000001,
    8'b01100011, 8'b10000101, 8'b01100001, 8'b01110001
  };

endpackage

// File: rtl/led_scan_display_seg7_decode.sv
// Combinational 5-bit digit code to active-low segment decoder; codes 0x10-0x1F are blank.
module seg7_decode
  import led_pkg::*;
(
  input  code_t code,
  output seg_t  seg
);

  always_comb begin
    seg = SEG_OFF;
    if (!code[4]) seg = GLYPHS[code[3:0]];
  end

endmodule

// File: rtl/led_scan_display.sv
// Time-multiplexed N-digit common-anode 7-segment driver with per-frame snapshot (tear-free).
// Optional digit blinking is compiled in when LED_SCAN_BLINK_EN is defined.
module led_scan_display
  import led_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int SCAN_DIV    = 20000,
`ifdef LED_SCAN_BLINK_EN
  parameter int BLINK_SLOTS = 400,
`endif
  parameter int IDX_W       = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DIGITS*5-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
`ifdef LED_SCAN_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  output logic [DIGITS-1:0]     led_en,
  output logic [7:0]            led_cx,
  output logic                  frame_tick
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0]      div_cnt;
  logic [IDX_W-1:0]      idx;
  logic [DIGITS*5-1:0]   shadow_data;
  logic [DIGITS-1:0]     shadow_dp;
  logic                  rearm;
  logic                  tc;
  logic                  last_digit;
  code_t                 cur_code;
  logic                  cur_dp;
  seg_t                  glyph;
  logic                  blink_dark;

  assign tc         = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign last_digit = (idx == IDX_W'(DIGITS - 1));
  assign cur_code   = shadow_data[int'(idx)*5 +: 5];
  assign cur_dp     = shadow_dp[idx];

  seg7_decode u_decode (
    .code (cur_code),
    .seg  (glyph)
  );

`ifdef LED_SCAN_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_SLOTS) + 1;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == BLINK_W'(BLINK_SLOTS - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  assign blink_dark = blink_phase & blink_mask[idx];
`else
  assign blink_dark = 1'b0;
`endif

  // rearm marks that the next enabled edge must take a fresh snapshot before anything is lit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      idx         <= '0;
      shadow_data <= {DIGITS{BLANK_CODE}};
      shadow_dp   <= '0;
      led_en      <= '1;
      led_cx      <= SEG_OFF;
      frame_tick  <= 1'b0;
      rearm       <= 1'b1;
    end else if (!en) begin
      div_cnt    <= '0;
      idx        <= '0;
      led_en     <= '1;
      led_cx     <= SEG_OFF;
      frame_tick <= 1'b0;
      rearm      <= 1'b1;
    end else if (rearm) begin
      shadow_data <= data;
      shadow_dp   <= dp;
      frame_tick  <= 1'b1;
      rearm       <= 1'b0;
      div_cnt     <= '0;
      idx         <= '0;
      led_en      <= '1;
      led_cx      <= SEG_OFF;
    end else begin
      led_en     <= ~(DIGITS'(1) << idx);
      led_cx     <= (cur_code[4] || blink_dark) ? SEG_OFF : {glyph[7:1], glyph[0] & ~cur_dp};
      frame_tick <= 1'b0;
      if (tc) begin
        div_cnt <= '0;
        if (last_digit) begin
          idx         <= '0;
          shadow_data <= data;
          shadow_dp   <= dp;
          frame_tick  <= 1'b1;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_led_scan_display.sv
// Scoreboard bench for led_scan_display (DIGITS=4, SCAN_DIV=4): expected digit frames are queued at each snapshot.
module tb_led_scan_display;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  typedef struct {
    logic [3:0] en;
    logic [7:0] cx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [19:0] data;
  logic [3:0]  dp;
  logic [3:0]  led_en;
  logic [7:0]  led_cx;
  logic        frame_tick;
`ifdef LED_SCAN_BLINK_EN
  logic [3:0]  blink_mask = 4'b0000;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  led_scan_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .data       (data),
    .dp         (dp),
`ifdef LED_SCAN_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .led_en     (led_en),
    .led_cx     (led_cx),
    .frame_tick (frame_tick)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] expSeg(input logic [4:0] code, input logic d);
    logic [6:0] g;
    if (code[4]) return 8'hFF;
    case (code[3:0])
      4'h0: g = 7'b0000001;  4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;  4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;  4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;  4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;  4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;  4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;  4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;  default: g = 7'b0111000;
    endcase
    return {g, ~d};
  endfunction

  task automatic applyStimulus(input logic [19:0] new_data, input logic [3:0] new_dp);
    data = new_data;
    dp   = new_dp;
  endtask

  // The snapshot just taken holds the inputs currently driven; queue the frame it will show.
  task automatic pushFrame();
    exp_t e;
    for (int k = 0; k < DIGITS; k++) begin
      e.en = ~(4'b0001 << k);
      e.cx = expSeg(data[5*k +: 5], dp[k]);
      sb.push_back(e);
    end
  endtask

  task automatic waitTick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 40);
    checkOutput("tick_wait", {31'd0, frame_tick}, 32'd1);
  endtask

  task automatic waitDigit(input logic [3:0] target);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (led_en !== target && n < 40);
    checkOutput("digit_wait", {28'd0, led_en}, {28'd0, target});
  endtask

  // Monitor: pops one expectation per newly selected digit, checks slot length and frame period.
  initial begin
    logic [3:0] prev = 4'hF;
    int run = 0;
    int gap = 0;
    bit tick_valid = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      gap++;
      if (!rst_n || !en) begin
        tick_valid = 1'b0;
      end else if (frame_tick) begin
        if (tick_valid) checkOutput("tick_period", gap, DIGITS * SCAN_DIV);
        tick_valid = 1'b1;
        gap = 0;
      end
      if (rst_n && led_en !== prev) begin
        if (prev != 4'hF && led_en != 4'hF) checkOutput("slot_len", run, SCAN_DIV);
        if (led_en != 4'hF) begin
          if (sb.size() == 0) begin
            checkOutput("sb_empty", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            checkOutput("digit_en", {28'd0, led_en}, {28'd0, e.en});
            checkOutput("digit_cx", {24'd0, led_cx}, {24'd0, e.cx});
          end
        end
        run = 1;
      end else begin
        run++;
      end
      prev = led_en;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    applyStimulus('0, '0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_led_en", {28'd0, led_en}, 32'hF);
      checkOutput("rst_led_cx", {24'd0, led_cx}, 32'hFF);
      checkOutput("rst_tick", {31'd0, frame_tick}, 32'd0);
    end

    applyStimulus({5'h3, 5'h2, 5'h1, 5'h0}, 4'b0000);
    en    = 1'b1;
    rst_n = 1'b1;
    waitTick();
    pushFrame();
    waitTick();
    pushFrame();

    // Change inputs mid-frame: the rest of this frame must still show the old snapshot.
    waitDigit(4'b1101);
    applyStimulus({4{5'h8}}, 4'b0000);
    waitTick();
    pushFrame();

    applyStimulus({5'h4, 5'h1F, 5'hA, 5'hF}, 4'b1110);
    waitTick();
    pushFrame();

    waitDigit(4'b1101);
    @(negedge clk);
    en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("off_led_en", {28'd0, led_en}, 32'hF);
      checkOutput("off_led_cx", {24'd0, led_cx}, 32'hFF);
      checkOutput("off_tick", {31'd0, frame_tick}, 32'd0);
    end
    sb.delete();

    applyStimulus({5'h7, 5'h5, 5'hC, 5'h9}, 4'b0001);
    en = 1'b1;
    @(negedge clk);
    checkOutput("reen_tick", {31'd0, frame_tick}, 32'd1);
    checkOutput("reen_dark", {28'd0, led_en}, 32'hF);
    pushFrame();
    waitTick();
    pushFrame();
    waitTick();
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_scan_display.md
Name: led_scan_display

Overview:
- Time-multiplexed driver for an N-digit common-anode 7-segment bank.
- Scans one digit per slot and snapshots all digit codes once per frame, so the display never tears.
- Decodes the 5-bit digit code (0x0–0xF hex, 0x1F blank) with per-digit decimal points.
- Sits between the application datapath and the board LED pins.

Parameters:
- DIGITS, 8: number of digits scanned; legal range 2..16.
- SCAN_DIV, 20000: clk cycles per digit slot; legal value ≥ 2. At 100 MHz this gives 5 kHz per digit.
- IDX_W, $clog2(DIGITS): digit index width. Derived; do not override.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst_n, input, 1: synchronous reset, active-low.
- en, input, 1: display enable; 0 turns all digits off.
- data, input, DIGITS*5: digit codes; digit k occupies bits [5k+4:5k]; digit 0 is rightmost.
- dp, input, DIGITS: decimal point request per digit, active-high.
- led_en, output, DIGITS: digit select, active-low, one-hot-low while scanning.
- led_cx, output, 8: segments {a,b,c,d,e,f,g,dp}, MSB = a, active-low.
- frame_tick, output, 1: one-cycle pulse when a new snapshot is taken.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - div_cnt=0, idx=0, shadow data=all 0x1F, shadow dp=0.
  - led_en=all 1s, led_cx=8'hFF, frame_tick=0.
- Divider:
  - While en=1, div_cnt counts 0..SCAN_DIV-1.
  - tc = (div_cnt==SCAN_DIV-1). On tc, div_cnt←0 and idx←idx+1, wrapping DIGITS-1→0.
  - Wrap is explicit, so non-power-of-2 DIGITS never visits illegal indices.
- Snapshot:
  - On tc with idx==DIGITS-1, shadow_data←data and shadow_dp←dp.
  - frame_tick=1 on the following cycle, for exactly one cycle.
  - Inputs may change at any time; only snapshot values are ever displayed.
- Outputs:
  - Both outputs are registered, with 1-cycle latency from idx/shadow to pins.
  - led_en = ~(1<<idx).
  - led_cx = decode(shadow_data[idx]), with bit0 = ~shadow_dp[idx].
- Decode rules:
  - Codes 0x0–0xF use the standard hex glyphs: 0→8'b00000011, 1→8'b10011111, 8→8'b00000001, A→8'b00010001, F→8'b01110001, with the dp bit forced to 1 before dp insertion.
  - Codes 0x10–0x1F are blank: led_cx=8'hFF regardless of dp, and the digit stays selected.
- Disable (en=0):
  - Next cycle led_en=all 1s and led_cx=8'hFF.
  - div_cnt and idx are cleared to 0; shadow is held; frame_tick=0.
- Re-enable (en 0→1):
  - First rising edge with en=1 takes a snapshot immediately (frame_tick pulses next cycle).
  - Digit 0 is displayed from the following cycle.
  - This prevents showing stale data after an enable gap.
- Simultaneous events:
  - rst_n=0 has priority over en.
  - en=0 has priority over tc.
- Reset mid-scan returns to the reset state on that edge; no partial slot completes.

Optional Feature:
- Macro LED_SCAN_BLINK_EN.
- When defined:
  - Adds parameter BLINK_SLOTS (default 400) and input blink_mask[DIGITS-1:0].
  - A blink counter advances on each frame_tick. blink_phase toggles after BLINK_SLOTS frames.
  - While blink_phase=1, digits with blink_mask[k]=1 output led_cx=8'hFF; they stay selected, so scan timing is unchanged.
  - blink_phase resets to 0.
  - en=0 clears both the counter and blink_phase.
- When undefined: no port, no counter; behaviour is identical to blink_mask=0.

Decomposition:
- Package led_pkg holds:
  - SEG_OFF=8'hFF, BLANK_CODE=5'h1F.
  - 16-entry glyph constant array (a..g, dp=1).
  - seg_t typedef (logic [7:0]) and code_t typedef (logic [4:0]).
- One combinational sub-module, seg7_decode (code_t in, seg_t out), using the package array.
- led_scan_display instantiates seg7_decode once, on the muxed shadow digit.

Test Plan:
- Reset: DIGITS=4, SCAN_DIV=4, hold rst_n=0 for 3 cycles → led_en=4'b1111, led_cx=8'hFF, frame_tick=0 throughout.
- Scan order: data={5'h3,5'h2,5'h1,5'h0}, dp=0, en=1 → led_en sequence 1110,1101,1011,0111 every 4 cycles, with led_cx=00000011,10011111,00100101,00001101; frame_tick once per 16 cycles.
- Tearing: change data mid-frame to all 5'h8 while idx=1 → remaining digits of the current frame still show old codes; 8'b00000001 appears on all digits only after the next frame_tick.
- Blank and dp: digit 2 = 5'h1F with dp[2]=1, digit 1 = 5'hA with dp[1]=1 → digit 2 led_cx=8'hFF, digit 1 led_cx=8'b00010000.
- Disable/re-enable: drop en for 5 cycles mid-slot → next cycle outputs off; on re-enable, frame_tick pulses after 1 cycle and digit 0 is shown first with the new data.
- Blink (LED_SCAN_BLINK_EN, BLINK_SLOTS=2): blink_mask=4'b0001 → digit 0 dark for 2 frames, lit for 2 frames; digits 1–3 never dark.
